// File: rtl/fix_ts_arbiter_if.sv
// Bundle of the timestamp generator, clock-set and encoder stream signals
// shared between the arbiter (master) and its surroundings (slave).
interface fix_ts_arbiter_if #(parameter int NUM_REQ = 4);
  logic [67:0]        ts_digits;
  logic               ts_settled;
  logic               ts_wren;
  logic [67:0]        ts_wdata;
  logic               set_req;
  logic [67:0]        set_digits;
  logic               set_ack;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [2:0]         out_owner;

  // Stream handshake: a byte transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid=1 and out_ready=0 the byte,
  // out_last and out_owner hold, and out_valid only drops after its transfer.
  modport master (
    input  ts_digits, ts_settled, set_req, set_digits, req, out_ready,
    output ts_wren, ts_wdata, set_ack, gnt, out_data, out_valid, out_last, out_owner
  );

  modport slave (
    output ts_digits, ts_settled, set_req, set_digits, req, out_ready,
    input  ts_wren, ts_wdata, set_ack, gnt, out_data, out_valid, out_last, out_owner
  );
endinterface

// File: rtl/fix_ts_arbiter.sv
// Arbitrates the FIX timestamp generator between clock-set writes and
// round-robin encoder requests; streams a 21-char ASCII snapshot per grant.
module fix_ts_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  fix_ts_arbiter_if.master bus,
  output logic [1:0]       o_state,
  output logic [2:0]       o_rr_ptr
);

  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, STREAM = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic [67:0]        r_snap, w_snap;
  logic [4:0]         r_idx, w_idx;
  logic [NUM_REQ-1:0] r_gnt, w_gnt;
  logic [2:0]         r_owner, w_owner;
  logic [2:0]         r_rr_ptr, w_rr_ptr;
  logic [7:0]         r_data, w_data;
  logic               r_valid, w_valid;
  logic               r_last, w_last;
  logic               r_wren, w_wren;
  logic [67:0]        r_wdata, w_wdata;
  logic               r_ack, w_ack;
  logic               w_found;
  logic [2:0]         w_win;

  // Character position -> byte: separators at 8/11/14/17, digits otherwise,
  // most significant digit first; non-BCD digits become '?'.
  function automatic logic [7:0] char_at(input logic [67:0] d, input logic [4:0] pos);
    int         w;
    logic [3:0] v;
    logic [7:0] c;
    w = int'(pos) - int'(pos > 5'd8) - int'(pos > 5'd11) - int'(pos > 5'd14) - int'(pos > 5'd17);
    v = d[4*(16-w) +: 4];
    c = (v > 4'd9) ? 8'h3F : {4'h3, v};
    case (pos)
      5'd8:         c = 8'h2D;
      5'd11, 5'd14: c = 8'h3A;
      5'd17:        c = 8'h2E;
      default:      ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = 3'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = r_snap;
    w_idx       = r_idx;
    w_gnt       = r_gnt;
    w_owner     = r_owner;
    w_rr_ptr    = r_rr_ptr;
    w_data      = r_data;
    w_valid     = r_valid;
    w_last      = r_last;
    w_wdata     = r_wdata;
    w_wren      = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.set_req) begin
          w_state_nxt = SET;
          w_wren      = 1'b1;
          w_ack       = 1'b1;
          w_wdata     = bus.set_digits;
        end else if (bus.ts_settled && w_found) begin
          w_state_nxt = STREAM;
          w_snap      = bus.ts_digits;
          w_gnt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          w_owner     = w_win;
          w_idx       = 5'd0;
          w_valid     = 1'b1;
          w_last      = 1'b0;
          w_data      = char_at(bus.ts_digits, 5'd0);
          w_rr_ptr    = (w_win == 3'(NUM_REQ-1)) ? 3'd0 : w_win + 3'd1;
        end
      end
      SET: w_state_nxt = IDLE;
      STREAM: begin
        if (bus.out_ready) begin
          if (r_idx == 5'd20) begin
            w_state_nxt = IDLE;
            w_gnt       = '0;
            w_valid     = 1'b0;
            w_last      = 1'b0;
            w_data      = 8'h00;
          end else begin
            w_idx  = r_idx + 5'd1;
            w_data = char_at(r_snap, r_idx + 5'd1);
            w_last = (r_idx == 5'd19);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_snap   <= '0;
      r_idx    <= '0;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_wren   <= 1'b0;
      r_wdata  <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_snap   <= w_snap;
      r_idx    <= w_idx;
      r_gnt    <= w_gnt;
      r_owner  <= w_owner;
      r_rr_ptr <= w_rr_ptr;
      r_data   <= w_data;
      r_valid  <= w_valid;
      r_last   <= w_last;
      r_wren   <= w_wren;
      r_wdata  <= w_wdata;
      r_ack    <= w_ack;
    end
  end

  assign bus.ts_wren   = r_wren;
  assign bus.ts_wdata  = r_wdata;
  assign bus.set_ack   = r_ack;
  assign bus.gnt       = r_gnt;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.out_owner = r_owner;
  assign o_state       = r_state;
  assign o_rr_ptr      = r_rr_ptr;

endmodule

// File: doc/fix_ts_arbiter.md
# fix_ts_arbiter

Shares the single FIX timestamp generator between up to NUM_REQ message encoders and its one clock-setting master. Each granted encoder receives a coherent snapshot of the 17 BCD digits, serialized as the 21-character ASCII field "YYYYMMDD-HH:MM:SS.sss", one byte per cycle over a valid/ready stream. Clock-set writes to the generator are sequenced here, so the generator is never written while a snapshot is being taken.

## Interface
- NUM_REQ, 4, number of encoder requesters (2..8)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ts_digits  in  68  generator digits; digit k = bits [4k+3:4k]; k=0 ms units … k=16 year thousands
- ts_settled  in  1  high when the generator has no carry ripple pending
- ts_wren  out  1  write enable to the generator
- ts_wdata  out  68  digits driven to the generator while ts_wren=1
- set_req  in  1  clock-set request; level, held until set_ack
- set_digits  in  68  new clock value, same packing as ts_digits
- set_ack  out  1  one-cycle pulse: set performed
- req  in  NUM_REQ  per-encoder timestamp request; level
- gnt  out  NUM_REQ  one-hot grant; high for the whole stream
- out_data  out  8  ASCII character
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_last  out  1  marks character 21
- out_owner  out  3  index of the granted requester

## Operation
- States: IDLE, SET, STREAM.
- IDLE, set_req=1: go to SET. Set has priority over all req.
- IDLE, set_req=0, any req bit=1, ts_settled=1:
  - Choose the winner by round-robin, searching from rr_ptr upward and wrapping.
  - Capture ts_digits into the snapshot register.
  - Set gnt, out_owner, and char index=0.
  - Set rr_ptr = winner+1 mod NUM_REQ.
  - Go to STREAM.
- IDLE, ts_settled=0: no grant; requests wait.
- SET (exactly one cycle): ts_wren=1, ts_wdata=set_digits, set_ack=1; then return to IDLE.
- STREAM:
  - out_valid=1.
  - Character order by digit index: 16,15,14,13,12,11,10,9,'-'(0x2D),8,7,':'(0x3A),6,5,':',4,3,'.'(0x2E),2,1,0.
  - Digit character = 0x30 + digit. A digit value >9 emits '?' (0x3F).
  - The index advances only on a handshake.
  - Handshake on index 20 (out_last=1): clear gnt, return to IDLE.
- Snapshot is held constant for the whole stream; generator updates during streaming are not reflected.
- req deassertion during STREAM is ignored; the stream always completes.
- set_req arriving during STREAM waits until IDLE.
- ts_wren is 0 in every state except SET.

## Timing
- Reset values: gnt=0, out_valid=0, out_last=0, out_data=0x00, out_owner=0, ts_wren=0, ts_wdata=0, set_ack=0, rr_ptr=0, state=IDLE.
- Reset mid-stream aborts the stream: all outputs take reset values on the next edge, with no out_last.
- Grant latency: req sampled high in IDLE at cycle N (settled, no set) gives gnt and out_valid with character 0 at cycle N+1.
- Full stream with out_ready held high: 21 cycles. Back-to-back grants: one IDLE cycle between streams.
- Valid/ready rules:
  - out_data, out_last and out_owner stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops before its handshake.
- Set latency: set_req high in IDLE at N gives ts_wren=1 and set_ack=1 at N+1, and IDLE at N+2.
- A set and a request in the same IDLE cycle: set wins; the request is considered at N+2 at the earliest.
- All outputs are registered.

## Test plan
- Single request, ready held high. ts_digits=2019-03-07 14:05:59.123, req[1]=1 → gnt=0010, 21 bytes "20190307-14:05:59.123", out_last on byte 21, gnt low the following cycle.
- Round-robin fairness: req=1111 held for four streams → owners 0,1,2,3 in order; after reset with req=1100 → owner 2 first.
- Backpressure: out_ready toggled 1/0 every cycle → each byte held stable until accepted; stream takes 41 cycles; no byte lost or duplicated.
- Settle gating: ts_settled=0 for 5 cycles with req[0]=1 → no gnt; grant on the cycle after ts_settled rises; snapshot equals ts_digits at that cycle.
- Set priority: set_req and req[2] asserted in the same cycle → ts_wren=1 with ts_wdata=set_digits and set_ack for exactly one cycle; stream for req[2] starts two cycles later.
- Reset mid-stream at byte 10 → next cycle gnt=0, out_valid=0, rr_ptr=0; a new req[3] streams from byte 0. A digit value of 0xA → byte '?'.
